// File: rtl/riscv_trace_pkg.sv
// Shared types and constants for the commit trace path.
package riscv_trace_pkg;

    localparam int unsigned TRACE_WIDTH     = 31;
    localparam int unsigned TRACE_REG       = 4;
    localparam int unsigned TRACE_SEQ       = 15;
    localparam int unsigned TRACE_DEPTH_LOG = 3;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    typedef struct packed {
        logic [TRACE_REG:0]   dest;
        logic [TRACE_WIDTH:0] result;
        logic [TRACE_SEQ:0]   seq;
    } traceEntry_t;

    localparam int unsigned ENTRY_W = $bits(traceEntry_t);

    // Saturating increment for the drop counter.
    function automatic logic [7:0] drop_sat_inc(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module trace_fifo_mem
    import riscv_trace_pkg::*;
#(
    parameter int unsigned ADDR_W = TRACE_DEPTH_LOG
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  traceEntry_t       i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output traceEntry_t       o_rd_data_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    traceEntry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Buffers retired (dest, result) pairs with a sequence tag and drains them over valid/ready;
// never stalls the core, reports losses through a sticky flag and a saturating counter.
module commit_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter int unsigned WIDTH     = TRACE_WIDTH,
    parameter int unsigned REG       = TRACE_REG,
    parameter int unsigned DEPTH_LOG = TRACE_DEPTH_LOG,
    parameter int unsigned SEQ       = TRACE_SEQ
) (
    input  logic               clk,
    input  logic               globalReset,
    input  logic               commitValid,
    input  logic [WIDTH:0]     commitResult,
    input  logic [REG:0]       commitDest,
    input  logic               outReady,
    input  logic               clearOverflow,
    output logic               outValid,
    output logic [WIDTH:0]     outResult,
    output logic [REG:0]       outDest,
    output logic [SEQ:0]       outSeq,
    output logic [DEPTH_LOG:0] count,
    output logic               overflow,
    output logic [7:0]         dropCount
);

    localparam int unsigned PTR_W = DEPTH_LOG + 1;
    localparam int unsigned CNT_W = DEPTH_LOG + 1;
    localparam int unsigned SEQ_W = SEQ + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [SEQ_W-1:0] r_seq;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;
    logic             r_out_valid;
    traceEntry_t      r_head;

    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_remain;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    traceEntry_t      w_wr_entry;
    traceEntry_t      w_rd_entry;
    traceEntry_t      w_head_nxt;

    assign w_pop        = r_out_valid && outReady;
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_push       = commitValid && (!w_full || w_pop);
    assign w_drop       = commitValid && w_full && !w_pop;
    assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_remain     = r_count - CNT_W'(w_pop);
    assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);

    assign w_wr_entry.dest   = commitDest;
    assign w_wr_entry.result = commitResult;
    assign w_wr_entry.seq    = r_seq;

    trace_fifo_mem #(
        .ADDR_W (DEPTH_LOG)
    ) u_mem (
        .clk         (clk),
        .i_wr_en     (w_push),
        .i_wr_addr   (r_wr_ptr[DEPTH_LOG-1:0]),
        .i_wr_data   (w_wr_entry),
        .i_rd_addr   (w_rd_ptr_nxt[DEPTH_LOG-1:0]),
        .o_rd_data_c (w_rd_entry)
    );

    // Next head: the already-stored entry if one survives this pop, else the incoming write.
    assign w_head_nxt = (w_remain != '0) ? w_rd_entry : w_wr_entry;

    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_seq    <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            if (commitValid) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
        end
    end

    // Registered FWFT head; held while the FIFO is empty.
    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            r_out_valid <= 1'b0;
            r_head      <= '0;
        end else begin
            r_out_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_head <= w_head_nxt;
            end
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= clearOverflow ? 8'd1 : drop_sat_inc(r_drop_cnt);
        end else if (clearOverflow) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign outValid  = r_out_valid;
    assign outResult = r_head.result;
    assign outDest   = r_head.dest;
    assign outSeq    = r_head.seq;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign dropCount = r_drop_cnt;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: queue-based reference model checked every cycle plus directed literals.
module tb_commit_trace_buffer;

    typedef struct {
        logic [4:0]  d;
        logic [31:0] r;
        logic [15:0] s;
    } ent_t;

    logic        clk;
    logic        globalReset;
    logic        commitValid;
    logic [31:0] commitResult;
    logic [4:0]  commitDest;
    logic        outReady;
    logic        clearOverflow;
    logic        outValid;
    logic [31:0] outResult;
    logic [4:0]  outDest;
    logic [15:0] outSeq;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  dropCount;

    int n_cmp = 0;
    int n_bad = 0;

    ent_t  mq[$];
    ent_t  dlog[$];
    logic [15:0] m_seq;
    logic        m_ovf;
    int          m_drop;

    commit_trace_buffer dut (
        .clk           (clk),
        .globalReset   (globalReset),
        .commitValid   (commitValid),
        .commitResult  (commitResult),
        .commitDest    (commitDest),
        .outReady      (outReady),
        .clearOverflow (clearOverflow),
        .outValid      (outValid),
        .outResult     (outResult),
        .outDest       (outDest),
        .outSeq        (outSeq),
        .count         (count),
        .overflow      (overflow),
        .dropCount     (dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: an 8-deep queue, a free-running tag and the loss bookkeeping.
    always @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            mq.delete();
            m_seq  <= '0;
            m_ovf  <= 1'b0;
            m_drop <= 0;
        end else begin
            bit   pop, full, push, drop;
            ent_t e;
            pop  = (mq.size() != 0) && outReady;
            full = (mq.size() == 8);
            push = commitValid && (!full || pop);
            drop = commitValid && full && !pop;
            e.d = commitDest;
            e.r = commitResult;
            e.s = m_seq;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
            if (commitValid) m_seq <= m_seq + 16'd1;
            if (drop) begin
                m_ovf  <= 1'b1;
                m_drop <= clearOverflow ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
            end else if (clearOverflow) begin
                m_ovf  <= 1'b0;
                m_drop <= 0;
            end
        end
    end

    // Per-cycle comparison against the model, and a log of entries handed to the consumer.
    always @(negedge clk) begin
        if (globalReset) begin
            chk("outValid", 32'(outValid), 32'(mq.size() != 0));
            chk("count", 32'(count), 32'(mq.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("dropCount", 32'(dropCount), 32'(m_drop));
            if (mq.size() != 0) begin
                chk("head_dest", 32'(outDest), 32'(mq[0].d));
                chk("head_result", outResult, mq[0].r);
                chk("head_seq", 32'(outSeq), 32'(mq[0].s));
            end
            if (outValid && outReady) begin
                ent_t e;
                e.d = outDest;
                e.r = outResult;
                e.s = outSeq;
                dlog.push_back(e);
            end
        end
    end

    task automatic drive(input logic cv, input logic [4:0] d, input logic [31:0] r,
                         input logic rdy, input logic clr);
        commitValid   = cv;
        commitDest    = d;
        commitResult  = r;
        outReady      = rdy;
        clearOverflow = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        commitValid   = 1'b0;
        commitDest    = '0;
        commitResult  = '0;
        outReady      = 1'b0;
        clearOverflow = 1'b0;
        globalReset   = 1'b0;
        @(posedge clk);
        #2;
        globalReset = 1'b1;
        dlog.delete();
    endtask

    initial begin
        globalReset   = 1'b1;
        commitValid   = 1'b0;
        commitDest    = '0;
        commitResult  = '0;
        outReady      = 1'b0;
        clearOverflow = 1'b0;
        #1 globalReset = 1'b0;
        #6;
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_dropCount", 32'(dropCount), 32'd0);
        @(posedge clk);
        #2;
        globalReset = 1'b1;

        // Passthrough with consumer always ready
        drive(1'b1, 5'd5, 32'h0000_00AA, 1'b1, 1'b0);
        drive(1'b1, 5'd6, 32'h0000_0BB0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("pass_n", 32'(dlog.size()), 32'd2);
        chk("pass0_dest", 32'(dlog[0].d), 32'd5);
        chk("pass0_res", dlog[0].r, 32'h0000_00AA);
        chk("pass0_seq", 32'(dlog[0].s), 32'd0);
        chk("pass1_dest", 32'(dlog[1].d), 32'd6);
        chk("pass1_res", dlog[1].r, 32'h0000_0BB0);
        chk("pass1_seq", 32'(dlog[1].s), 32'd1);
        chk("pass_count", 32'(count), 32'd0);

        // Fill past capacity with a stalled consumer, then drain
        do_reset();
        for (int i = 0; i < 10; i++) drive(1'b1, 5'(i), 32'h1000 + 32'(i), 1'b0, 1'b0);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_ovf", 32'(overflow), 32'd1);
        chk("fill_drop", 32'(dropCount), 32'd2);
        dlog.delete();
        for (int i = 0; i < 9; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drain_n", 32'(dlog.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("drain_seq", 32'(dlog[i].s), 32'(i));
        dlog.delete();
        drive(1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("after_drop_seq", 32'(dlog[0].s), 32'd10);

        // Simultaneous push and pop while full
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 5'(i), 32'h2000 + 32'(i), 1'b0, 1'b0);
        dlog.delete();
        for (int i = 0; i < 4; i++) drive(1'b1, 5'(8 + i), 32'h2100 + 32'(i), 1'b1, 1'b0);
        chk("pp_count", 32'(count), 32'd8);
        chk("pp_drop", 32'(dropCount), 32'd0);
        chk("pp_n", 32'(dlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("pp_seq", 32'(dlog[i].s), 32'(i));

        // clearOverflow alone, then colliding with a drop
        for (int i = 0; i < 3; i++) drive(1'b1, 5'd1, 32'h3000, 1'b0, 1'b0);
        chk("clr_pre_ovf", 32'(overflow), 32'd1);
        chk("clr_pre_drop", 32'(dropCount), 32'd3);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_drop", 32'(dropCount), 32'd0);
        drive(1'b1, 5'd2, 32'h3001, 1'b0, 1'b1);
        chk("coll_ovf", 32'(overflow), 32'd1);
        chk("coll_drop", 32'(dropCount), 32'd1);
        chk("coll_count", 32'(count), 32'd8);

        // Asynchronous reset between clock edges while entries are pending
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b0, 1'b0);
        chk("mid_count", 32'(count), 32'd5);
        chk("mid_valid", 32'(outValid), 32'd1);
        chk("mid_res", outResult, 32'h100);
        globalReset = 1'b0;
        #1;
        chk("ar_valid", 32'(outValid), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_res", outResult, 32'd0);
        chk("ar_dest", 32'(outDest), 32'd0);
        chk("ar_seq", 32'(outSeq), 32'd0);
        #1;
        globalReset = 1'b1;
        dlog.delete();
        drive(1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("ar_next_n", 32'(dlog.size()), 32'd1);
        chk("ar_next_seq", 32'(dlog[0].s), 32'd0);
        chk("ar_next_dest", 32'(dlog[0].d), 32'd9);

        drive(1'b0, '0, '0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
